// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared types and helpers for the Gray-code pointer crossing blocks.
//   - state_e    : decoder FSM states (FILL, FIRST, RUN)
//   - bin2gray   : binary -> Gray conversion
//   - gray2bin   : Gray -> binary conversion
//   - popcount   : number of set bits, used as a Hamming-distance helper
// The helpers work on a fixed-width container (GRAY_MAX_W bits). Callers
// zero-extend narrower words into it and cast the result back down. Zero
// upper bits leave both conversions unchanged, so one function body covers
// every width up to GRAY_MAX_W.
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_MAX_W = 64;

  typedef enum logic [1:0] {
    FILL,
    FIRST,
    RUN
  } state_e;

  // Each Gray bit is the XOR of a binary bit and its upper neighbour.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bits are a running XOR taken from the MSB down.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] x);
    int unsigned n;
    n = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      if (x[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync_decoder_if.sv
// ---------------------------------------------------------------------------
// gray_sync_decoder_if
// Bundles the data and status signals of gray_sync_decoder.
//   gray_in    : Gray word from the upstream counter (may be asynchronous)
//   clr_err    : synchronous clear of the error bookkeeping
//   bin_out    : registered binary value of the synchronised sample
//   bin_valid  : bin_out holds a real sample
//   delta      : bin_out minus previous bin_out, modulo 2^DATA_WIDTH
//   step_err   : one-cycle pulse on a multi-bit Gray step
//   err_cnt    : saturating count of step_err pulses
//   err_sticky : set by step_err, held until clr_err or reset
// master drives gray_in/clr_err (upstream/test side); slave is the decoder.
// ---------------------------------------------------------------------------
interface gray_sync_decoder_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
);

  logic [DATA_WIDTH-1:0]    gray_in;
  logic                     clr_err;
  logic [DATA_WIDTH-1:0]    bin_out;
  logic                     bin_valid;
  logic [DATA_WIDTH-1:0]    delta;
  logic                     step_err;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic                     err_sticky;

  modport master (
    output gray_in,
    output clr_err,
    input  bin_out,
    input  bin_valid,
    input  delta,
    input  step_err,
    input  err_cnt,
    input  err_sticky
  );

  modport slave (
    input  gray_in,
    input  clr_err,
    output bin_out,
    output bin_valid,
    output delta,
    output step_err,
    output err_cnt,
    output err_sticky
  );

endinterface

// File: rtl/gray_sync_chain.sv
// ---------------------------------------------------------------------------
// gray_sync_chain
// Multi-bit flop chain for bringing a Gray-coded word into the clk domain.
// Only safe for words where at most one bit changes per source update.
//   clk_i    : rising-edge clock
//   resetn_i : synchronous active-low reset, clears every stage
//   d_i      : input word (may be asynchronous to clk_i)
//   q_o      : output of the last stage, STAGES edges after capture
// ---------------------------------------------------------------------------
module gray_sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Stage 0 sits in the lowest slot; every edge shifts one slot upward.
  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  // Shift register: stage 0 captures d_i, later stages copy their neighbour.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// ---------------------------------------------------------------------------
// gray_sync_decoder
// Consumer of a free-running Gray counter. It synchronises the Gray word,
// converts it to binary, reports the per-sample binary delta, and flags and
// counts samples whose Gray step changes more than one bit.
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset; outputs read 0 after a reset edge
//   bus    : gray_sync_decoder_if.slave carrying gray_in, clr_err, bin_out,
//            bin_valid, delta, step_err, err_cnt, err_sticky
// Supports DATA_WIDTH from 2 up to gray_pkg::GRAY_MAX_W.
// ---------------------------------------------------------------------------
module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                resetn,
  gray_sync_decoder_if.slave  bus
);

  localparam int FILL_W = $clog2(SYNC_STAGES) + 1;

  state_e                   state_q;
  logic [FILL_W-1:0]        fillCnt_q;
  logic [DATA_WIDTH-1:0]    gPrev_q;
  logic [DATA_WIDTH-1:0]    binOut_q;
  logic                     binValid_q;
  logic [DATA_WIDTH-1:0]    delta_q;
  logic                     stepErr_q;
  logic [ERR_CNT_WIDTH-1:0] errCnt_q;
  logic                     errSticky_q;

  logic [DATA_WIDTH-1:0]    gCur;
  logic [DATA_WIDTH-1:0]    binNew;
  int unsigned              hamming;
  logic                     stepErr_d;
  logic [ERR_CNT_WIDTH-1:0] errBase;
  logic [ERR_CNT_WIDTH-1:0] errCnt_d;
  logic                     errSticky_d;

  gray_sync_chain #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk),
    .resetn_i (resetn),
    .d_i      (bus.gray_in),
    .q_o      (gCur)
  );

  // Conversion and step check on the synchronised sample. Only RUN has a
  // meaningful previous sample, so checks are gated to that state.
  always_comb begin
    binNew    = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(gCur)));
    hamming   = popcount(GRAY_MAX_W'(gCur ^ gPrev_q));
    stepErr_d = (state_q == RUN) && (hamming > 1);
  end

  // Error bookkeeping: a clear is applied before a same-edge increment, so
  // clear plus error leaves a count of one and the sticky bit set.
  always_comb begin
    errBase     = bus.clr_err ? '0 : errCnt_q;
    errCnt_d    = errBase;
    errSticky_d = bus.clr_err ? 1'b0 : errSticky_q;
    if (stepErr_d) begin
      errSticky_d = 1'b1;
      if (errBase != '1) begin
        errCnt_d = errBase + ERR_CNT_WIDTH'(1);
      end
    end
  end

  // FILL waits until the chain holds only post-reset samples, FIRST takes
  // the first sample without a step check, RUN updates every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= FILL;
      fillCnt_q   <= '0;
      gPrev_q     <= '0;
      binOut_q    <= '0;
      binValid_q  <= 1'b0;
      delta_q     <= '0;
      stepErr_q   <= 1'b0;
      errCnt_q    <= '0;
      errSticky_q <= 1'b0;
    end else begin
      stepErr_q   <= stepErr_d;
      errCnt_q    <= errCnt_d;
      errSticky_q <= errSticky_d;
      case (state_q)
        FILL: begin
          if (fillCnt_q == FILL_W'(SYNC_STAGES - 1)) begin
            state_q <= FIRST;
          end else begin
            fillCnt_q <= fillCnt_q + FILL_W'(1);
          end
        end
        FIRST: begin
          binOut_q   <= binNew;
          binValid_q <= 1'b1;
          delta_q    <= '0;
          gPrev_q    <= gCur;
          state_q    <= RUN;
        end
        RUN: begin
          binOut_q <= binNew;
          delta_q  <= binNew - binOut_q;
          gPrev_q  <= gCur;
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign bus.bin_out    = binOut_q;
  assign bus.bin_valid  = binValid_q;
  assign bus.delta      = delta_q;
  assign bus.step_err   = stepErr_q;
  assign bus.err_cnt    = errCnt_q;
  assign bus.err_sticky = errSticky_q;

endmodule
